// File: rtl/resc_pkg.sv
// Shared constants, LFSR seeds and FSM state type for the ReSC Bernstein evaluator.
package resc_pkg;

  localparam int WIDTH      = 10;
  localparam int DEGREE     = 3;
  localparam int STREAM_LEN = 1 << WIDTH;
  localparam int CNT_W      = WIDTH + 1;

  // Bernstein coefficients b0..b3 scaled by 2**WIDTH; COEFFS[0] is b0.
  localparam logic [DEGREE:0][WIDTH-1:0] COEFFS = {10'd768, 10'd384, 10'd640, 10'd256};

  // x^10 + x^7 + 1 feedback taps, expressed as bit positions 9 and 6.
  localparam logic [WIDTH-1:0] TAP_MASK = 10'h240;

  localparam logic [WIDTH-1:0] SEED_X0 = 10'h001;
  localparam logic [WIDTH-1:0] SEED_X1 = 10'h0A5;
  localparam logic [WIDTH-1:0] SEED_X2 = 10'h15A;
  localparam logic [WIDTH-1:0] SEED_C  = 10'h2C3;

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    RUN,
    DONE
  } state_t;

  // A full stream of ones reaches 2**WIDTH, which does not fit the result port.
  function automatic logic [WIDTH-1:0] sat_count(input logic [CNT_W-1:0] count);
    return count[WIDTH] ? {WIDTH{1'b1}} : count[WIDTH-1:0];
  endfunction

endpackage

// File: rtl/resc_lfsr.sv
// 10-bit Fibonacci LFSR random source; reloads its seed on reset or load, steps when enabled.
module resc_lfsr
  import resc_pkg::*;
#(
  parameter logic [WIDTH-1:0] SEED = 10'h001
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic             enable,
  output logic [WIDTH-1:0] state
);

  always_ff @(posedge clk) begin
    if (reset || load) begin
      state <= SEED;
    end else if (enable) begin
      state <= {state[WIDTH-2:0], ^(state & TAP_MASK)};
    end
  end

endmodule

// File: rtl/resc_wrapper_paper_example.sv
// ReSC evaluator for y = 1/4 + 9/8 x - 15/8 x^2 + 5/4 x^3 using a 1024-bit stochastic stream.
module resc_wrapper_paper_example
  import resc_pkg::*;
(
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] x_bin,
  output logic             done,
  output logic [WIDTH-1:0] y_bin
);

  state_t           state_q;
  state_t           state_d;
  logic [WIDTH-1:0] x_reg;
  logic [WIDTH-1:0] bit_cnt;
  logic [CNT_W-1:0] ones_cnt;
  logic [WIDTH-1:0] rand_x0;
  logic [WIDTH-1:0] rand_x1;
  logic [WIDTH-1:0] rand_x2;
  logic [WIDTH-1:0] rand_c;
  logic             lfsr_load;
  logic             lfsr_en;
  logic             last_bit;
  logic             x0;
  logic             x1;
  logic             x2;
  logic [1:0]       sel;
  logic             z;

  resc_lfsr #(.SEED(SEED_X0)) u_lfsr_x0 (
    .clk(clk), .reset(reset), .load(lfsr_load), .enable(lfsr_en), .state(rand_x0)
  );
  resc_lfsr #(.SEED(SEED_X1)) u_lfsr_x1 (
    .clk(clk), .reset(reset), .load(lfsr_load), .enable(lfsr_en), .state(rand_x1)
  );
  resc_lfsr #(.SEED(SEED_X2)) u_lfsr_x2 (
    .clk(clk), .reset(reset), .load(lfsr_load), .enable(lfsr_en), .state(rand_x2)
  );
  resc_lfsr #(.SEED(SEED_C)) u_lfsr_c (
    .clk(clk), .reset(reset), .load(lfsr_load), .enable(lfsr_en), .state(rand_c)
  );

  // ReSC core: the number of ones among the x bits selects which coefficient stream to emit.
  always_comb begin
    x0       = rand_x0 < x_reg;
    x1       = rand_x1 < x_reg;
    x2       = rand_x2 < x_reg;
    sel      = 2'(x0) + 2'(x1) + 2'(x2);
    z        = rand_c < COEFFS[sel];
    last_bit = bit_cnt == WIDTH'(STREAM_LEN - 1);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // start dominates every state so a conversion can be aborted at any point.
  always_comb begin
    state_d   = state_q;
    lfsr_load = 1'b0;
    lfsr_en   = 1'b0;
    case (state_q)
      IDLE: state_d = IDLE;
      LOAD: begin
        lfsr_load = 1'b1;
        state_d   = RUN;
      end
      RUN: begin
        lfsr_en = 1'b1;
        if (last_bit) begin
          state_d = DONE;
        end
      end
      DONE: state_d = DONE;
      default: state_d = IDLE;
    endcase
    if (start) begin
      state_d = LOAD;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      x_reg    <= '0;
      bit_cnt  <= '0;
      ones_cnt <= '0;
      y_bin    <= '0;
      done     <= 1'b0;
    end else begin
      case (state_q)
        LOAD: begin
          bit_cnt  <= '0;
          ones_cnt <= '0;
          if (!start) begin
            x_reg <= x_bin;
          end
        end
        RUN: begin
          bit_cnt  <= bit_cnt + 1'b1;
          ones_cnt <= ones_cnt + CNT_W'(z);
          if (last_bit && !start) begin
            y_bin <= sat_count(ones_cnt + CNT_W'(z));
            done  <= 1'b1;
          end
        end
        default: ;
      endcase
      if (start) begin
        done <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_resc_wrapper_paper_example.sv
// Directed self-checking bench for the ReSC evaluator: latency, accuracy, abort, hold and reset.
module tb_resc_wrapper_paper_example;

  localparam int LATENCY    = 1025;
  localparam int WAIT_LIMIT = 3000;
  localparam int TOL        = 20;

  logic       clk = 1'b0;
  logic       reset;
  logic       start;
  logic [9:0] x_bin;
  logic       done;
  logic [9:0] y_bin;

  int assertCount = 0;
  int failCount   = 0;

  always #5 clk = ~clk;

  resc_wrapper_paper_example dut (
    .clk(clk),
    .reset(reset),
    .start(start),
    .x_bin(x_bin),
    .done(done),
    .y_bin(y_bin)
  );

  task automatic checkOutput(input string tag, input int observed, input int expected, input int tol);
    int diff;
    assertCount++;
    diff = observed - expected;
    if (diff < 0) diff = -diff;
    if (diff > tol) begin
      failCount++;
      $display("[TB] FAIL %s: observed %0d, expected %0d (tolerance %0d)", tag, observed, expected, tol);
    end
  endtask

  // One-cycle start pulse, then release start with the new operand.
  task automatic applyStimulus(input logic [9:0] x);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    x_bin = x;
  endtask

  task automatic waitDone(output int cycles);
    cycles = 0;
    while (!done && cycles < WAIT_LIMIT) begin
      @(negedge clk);
      cycles++;
    end
  endtask

  task automatic runConversion(input string tag, input logic [9:0] x, input int expY);
    int cycles;
    applyStimulus(x);
    checkOutput({tag, "_done_clr"}, int'(done), 0, 0);
    waitDone(cycles);
    checkOutput({tag, "_latency"}, cycles, LATENCY, 0);
    checkOutput({tag, "_y"}, int'(y_bin), expY, TOL);
  endtask

  int xs [10] = '{444, 51, 520, 119, 986, 319, 554, 1003, 241, 260};
  int ys [10] = '{499, 309, 514, 366, 727, 467, 520, 746, 438, 446};

  initial begin
    int sawDone;
    int changes;

    reset = 1'b1;
    start = 1'b1;
    x_bin = '0;
    @(negedge clk);
    checkOutput("reset_done", int'(done), 0, 0);
    checkOutput("reset_y", int'(y_bin), 0, 0);
    reset = 1'b0;
    @(negedge clk);
    checkOutput("load_done", int'(done), 0, 0);

    runConversion("first", 10'd679, 549);

    for (int i = 0; i < 10; i++) begin
      runConversion($sformatf("seq%0d", i), 10'(xs[i]), ys[i]);
    end

    runConversion("x_min", 10'd0, 256);
    runConversion("x_max", 10'd1023, 768);

    applyStimulus(10'd679);
    sawDone = 0;
    repeat (500) begin
      @(negedge clk);
      if (done) sawDone = 1;
    end
    checkOutput("abort_no_done", sawDone, 0, 0);
    runConversion("abort_restart", 10'd51, 309);

    changes = 0;
    repeat (3000) begin
      x_bin = 10'($urandom_range(0, 1023));
      @(negedge clk);
      if (done !== 1'b1 || y_bin !== 10'd0 + y_bin) changes++;
      if (int'(y_bin) < 309 - TOL || int'(y_bin) > 309 + TOL) changes++;
    end
    checkOutput("hold_changes", changes, 0, 0);
    checkOutput("hold_done", int'(done), 1, 0);
    checkOutput("hold_y", int'(y_bin), 309, TOL);

    applyStimulus(10'd444);
    repeat (300) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    checkOutput("midrun_reset_done", int'(done), 0, 0);
    checkOutput("midrun_reset_y", int'(y_bin), 0, 0);
    sawDone = 0;
    repeat (1200) begin
      @(negedge clk);
      if (done) sawDone = 1;
    end
    checkOutput("idle_no_done", sawDone, 0, 0);
    runConversion("post_reset", 10'd520, 514);

    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule
